// File: rtl/eth_send_sched.sv
// eth_send_sched: sequencer in front of EthSend.
//
// Chooses what each Ethernet packet carries. Dirty memory sources are served
// round-robin, and a background (BG) keep-alive is sent after BG_PERIOD idle
// clocks. The block tracks a 2-bit sequence number and retransmits
// unacknowledged MEM packets with an increasing dup count. Once MAX_DUP is
// exceeded it forces an SN resync.
//
// Ports:
//   clk, reset_i            clock, asynchronous active-high reset
//   dirty_i[NSRC]           per-source pending-region flags
//   src_en_o[NSRC]          one-hot enable of the selected source (MEM only)
//   start_o, reset_sn_o     one-clock control pulses to EthSend
//   sel_o[8], sn_o[4]       packet select ({2'b10,idx} MEM, 8'h00 BG), {dup,sn}
//   busy_i, done_i          EthSend status
//   ack_valid_i, ack_sn_i   acknowledge from the receive path
//   sched_busy_o            high whenever the sequencer is not idle
module eth_send_sched #(
    parameter int NSRC      = 4,
    parameter int BG_PERIOD = 1000,
    parameter int ACK_TMO   = 4000,
    parameter int MAX_DUP   = 3
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic [NSRC-1:0] dirty_i,
    output logic [NSRC-1:0] src_en_o,
    output logic            start_o,
    output logic            reset_sn_o,
    output logic [7:0]      sel_o,
    output logic [3:0]      sn_o,
    input  logic            busy_i,
    input  logic            done_i,
    input  logic            ack_valid_i,
    input  logic [1:0]      ack_sn_i,
    output logic            sched_busy_o
);

    localparam int IW  = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int BGW = $clog2(BG_PERIOD + 1);
    localparam int TW  = $clog2(ACK_TMO + 1);
    localparam logic [BGW-1:0] BG_LAST  = BGW'(BG_PERIOD - 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(ACK_TMO - 1);
    localparam logic [1:0]     DUP_MAX  = 2'(MAX_DUP);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NSRC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_START, S_WAIT_DONE, S_WAIT_ACK, S_RESYNC
    } state_t;

    // Descriptor of the packet in flight; stays fixed across retransmits
    // except for dup.
    typedef struct packed {
        logic          bg;
        logic [IW-1:0] idx;
        logic [1:0]    dup;
    } pkt_t;

    state_t         state, state_n;
    pkt_t           pkt, pkt_n;
    logic [1:0]     cur_sn, cur_sn_n;
    logic [IW-1:0]  rr_ptr, rr_n;
    logic [BGW-1:0] bg_cnt, bg_n;
    logic [TW-1:0]  tmo, tmo_n;
    logic [1:0]     wd_cnt, wd_n;
    logic           busy_seen, seen_n;

    logic           pick_vld;
    logic [IW-1:0]  pick_idx;
    logic [IW-1:0]  pick_j;
    logic [IW-1:0]  idx_nxt;

    // First dirty source at or after rr_ptr, wrapping. The loop runs from the
    // farthest offset down so the nearest one is the last assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_j   = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            pick_j = IW'((int'(rr_ptr) + k) % NSRC);
            if (dirty_i[pick_j]) begin
                pick_vld = 1'b1;
                pick_idx = pick_j;
            end
        end
    end

    assign idx_nxt = (pkt.idx == IDX_LAST) ? '0 : pkt.idx + 1'b1;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state     <= S_IDLE;
            pkt       <= '0;
            cur_sn    <= 2'd1;
            rr_ptr    <= '0;
            bg_cnt    <= '0;
            tmo       <= '0;
            wd_cnt    <= '0;
            busy_seen <= 1'b0;
        end else begin
            state     <= state_n;
            pkt       <= pkt_n;
            cur_sn    <= cur_sn_n;
            rr_ptr    <= rr_n;
            bg_cnt    <= bg_n;
            tmo       <= tmo_n;
            wd_cnt    <= wd_n;
            busy_seen <= seen_n;
        end
    end

    always_comb begin
        state_n  = state;
        pkt_n    = pkt;
        cur_sn_n = cur_sn;
        rr_n     = rr_ptr;
        bg_n     = bg_cnt;
        tmo_n    = tmo;
        wd_n     = wd_cnt;
        seen_n   = busy_seen;
        case (state)
            S_IDLE: begin
                // A dirty source wins over a BG expiry in the same clock.
                // bg_cnt is left alone in that case.
                if (pick_vld) begin
                    pkt_n   = '{bg: 1'b0, idx: pick_idx, dup: 2'd1};
                    state_n = S_ARM;
                end else if (bg_cnt == BG_LAST) begin
                    bg_n    = '0;
                    pkt_n   = '{bg: 1'b1, idx: '0, dup: 2'd0};
                    state_n = S_ARM;
                end else begin
                    bg_n = bg_cnt + 1'b1;
                end
            end
            S_ARM: state_n = S_START;
            S_START: begin
                // Hold the start back while EthSend still reports busy.
                if (!busy_i) begin
                    state_n = S_WAIT_DONE;
                    wd_n    = '0;
                    seen_n  = 1'b0;
                end
            end
            S_WAIT_DONE: begin
                if (done_i) begin
                    tmo_n   = '0;
                    state_n = pkt.bg ? S_IDLE : S_WAIT_ACK;
                end else if (busy_i) begin
                    seen_n = 1'b1;
                end else if (!busy_seen) begin
                    // EthSend never went busy: abandon this attempt.
                    if (wd_cnt == 2'd3) state_n = S_IDLE;
                    else                wd_n    = wd_cnt + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (ack_valid_i && ack_sn_i == cur_sn) begin
                    cur_sn_n = (cur_sn == 2'd3) ? 2'd1 : cur_sn + 1'b1;
                    rr_n     = idx_nxt;
                    state_n  = S_IDLE;
                end else if (tmo == TMO_LAST) begin
                    if (pkt.dup < DUP_MAX) begin
                        pkt_n.dup = pkt.dup + 1'b1;
                        state_n   = S_ARM;
                    end else begin
                        state_n = S_RESYNC;
                    end
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            S_RESYNC: begin
                cur_sn_n = 2'd1;
                rr_n     = idx_nxt;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Packet fields are visible only from ARM through WAIT_DONE.
    logic in_pkt, mem_pkt;
    assign in_pkt  = (state == S_ARM) || (state == S_START) || (state == S_WAIT_DONE);
    assign mem_pkt = in_pkt && !pkt.bg;

    assign src_en_o     = mem_pkt ? (NSRC'(1) << pkt.idx) : '0;
    assign sel_o        = mem_pkt ? {2'b10, 6'(pkt.idx)} : 8'h00;
    assign sn_o         = mem_pkt ? {pkt.dup, cur_sn} : 4'h0;
    assign start_o      = (state == S_START) && !busy_i;
    assign reset_sn_o   = (state == S_RESYNC);
    assign sched_busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_eth_send_sched.sv
// Testbench for eth_send_sched. The bench plays EthSend and the receive path.
// The model predicts each packet's contents and the clock in which start_o
// must appear.
module tb_eth_send_sched;
    localparam int NSRC = 4, BGP = 10, TMO = 20, MAXD = 3;

    logic clk = 1'b0, reset_i = 1'b1;
    logic [NSRC-1:0] dirty_i = '0;
    logic busy_i = 1'b0, done_i = 1'b0, ack_valid_i = 1'b0;
    logic [1:0] ack_sn_i = 2'd0;
    logic [NSRC-1:0] src_en_o;
    logic start_o, reset_sn_o, sched_busy_o;
    logic [7:0] sel_o;
    logic [3:0] sn_o;

    eth_send_sched #(.NSRC(NSRC), .BG_PERIOD(BGP), .ACK_TMO(TMO), .MAX_DUP(MAXD)) dut (
        .clk(clk), .reset_i(reset_i), .dirty_i(dirty_i), .src_en_o(src_en_o),
        .start_o(start_o), .reset_sn_o(reset_sn_o), .sel_o(sel_o), .sn_o(sn_o),
        .busy_i(busy_i), .done_i(done_i), .ack_valid_i(ack_valid_i),
        .ack_sn_i(ack_sn_i), .sched_busy_o(sched_busy_o));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state
    int m_rr, m_sn, m_dup, m_idx;
    bit m_bg;
    int exp_start = -1, exp_rsn = -1;
    logic [7:0] exp_sel;
    logic [3:0] exp_sn;
    logic [NSRC-1:0] exp_en;
    bit chk_en = 0, in_flight = 0;
    int last_s, rel, rsn_cnt = 0;
    logic [7:0] obs_sel;
    logic [3:0] obs_sn;

    function automatic int pick(logic [NSRC-1:0] m, int rr);
        for (int k = 0; k < NSRC; k++)
            if (m[(rr + k) % NSRC]) return (rr + k) % NSRC;
        return 0;
    endfunction

    task automatic set_exp();
        if (m_bg) begin
            exp_sel = 8'h00; exp_sn = 4'h0; exp_en = '0;
        end else begin
            exp_sel = 8'(128 + m_idx);
            exp_sn  = 4'(m_dup * 4 + m_sn);
            exp_en  = NSRC'(1) << m_idx;
        end
    endtask

    task automatic plan_mem();
        m_bg = 0; m_idx = pick(dirty_i, m_rr); m_dup = 1; set_exp();
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset_sn_o) rsn_cnt++;
        if (chk_en) begin
            chk("start", start_o, cyc == exp_start);
            chk("reset_sn", reset_sn_o, cyc == exp_rsn);
            chk("start_while_busy", start_o & busy_i, 0);
            if (start_o || cyc == exp_start) begin
                chk("sel", sel_o, exp_sel);
                chk("sn", sn_o, exp_sn);
                chk("src_en", src_en_o, exp_en);
                chk("sched_busy", sched_busy_o, 1);
            end else if (in_flight) begin
                chk("hold_sel", sel_o, exp_sel);
                chk("hold_sn", sn_o, exp_sn);
                chk("hold_src_en", src_en_o, exp_en);
            end
        end
    end

    task automatic do_reset(logic [NSRC-1:0] mask);
        chk_en = 0; in_flight = 0;
        reset_i = 1; busy_i = 0; done_i = 0; ack_valid_i = 0; dirty_i = mask;
        repeat (2) @(posedge clk);
        #1 reset_i = 0;
        rel = cyc; m_rr = 0; m_sn = 1; exp_rsn = -1;
        if (mask != 0) begin plan_mem(); exp_start = cyc + 2; end
        else begin m_bg = 1; set_exp(); exp_start = cyc + BGP + 1; end
        chk_en = 1;
    endtask

    // Returns #1 after the clock following start_o.
    task automatic wait_start();
        int n = 0;
        do begin @(negedge clk); n++; end while (!start_o && n < 400);
        if (!start_o) begin
            checks++; errors++;
            $display("FAIL start_timeout: got no start_o within 400 clocks (cycle %0d)", cyc);
        end
        last_s = cyc; obs_sel = sel_o; obs_sn = sn_o;
        @(posedge clk); #1;
    endtask

    // resp: 0 correct ack at clock k after done, 1 wrong ack then timeout,
    //       2 no ack (timeout), 3 EthSend never goes busy
    task automatic do_pkt(int resp, int k, int len, logic [NSRC-1:0] nmask);
        int d;
        wait_start();
        if (resp == 3) begin plan_mem(); exp_start = last_s + 7; return; end
        busy_i = 1; in_flight = 1;
        repeat (len) @(posedge clk);
        #1 busy_i = 0; done_i = 1; d = cyc + 1;
        @(posedge clk);
        #1 done_i = 0; in_flight = 0;
        if (m_bg) begin exp_start = d + BGP + 1; return; end
        if (resp <= 1) begin
            if (k > 1) begin repeat (k - 1) @(posedge clk); #1; end
            ack_valid_i = 1;
            ack_sn_i = 2'((resp == 0) ? m_sn : (m_sn + 1) % 4);
            if (resp == 0) dirty_i = nmask;
            @(posedge clk);
            #1 ack_valid_i = 0;
        end
        if (resp == 0) begin
            m_sn = (m_sn == 3) ? 1 : m_sn + 1;
            m_rr = (m_idx + 1) % NSRC;
            plan_mem(); exp_start = d + k + 2;
        end else if (m_dup < MAXD) begin
            m_dup++; set_exp(); exp_start = d + TMO + 1;
        end else begin
            exp_rsn = d + TMO; m_sn = 1; m_rr = (m_idx + 1) % NSRC;
            plan_mem(); exp_start = d + TMO + 3;
        end
    endtask

    logic [7:0] t2_sel [4] = '{8'h80, 8'h82, 8'h80, 8'h82};
    logic [3:0] t2_sn  [4] = '{4'h5, 4'h6, 4'h7, 4'h5};
    logic [3:0] t3_sn  [3] = '{4'h5, 4'h9, 4'hD};

    initial begin
        int s1, r0, resp;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", start_o, 0);   chk("rst_src_en", src_en_o, 0);
        chk("rst_sel", sel_o, 0);       chk("rst_sn", sn_o, 0);
        chk("rst_reset_sn", reset_sn_o, 0); chk("rst_sched_busy", sched_busy_o, 0);

        // BG keep-alives
        do_reset('0);
        do_pkt(0, 1, 3, '0);
        chk("bg_first_latency", last_s - rel, 11);
        chk("bg_sel_lit", obs_sel, 8'h00);
        s1 = last_s;
        do_pkt(0, 1, 3, '0);
        chk("bg_gap", last_s - s1, 16);
        do_pkt(0, 1, 5, '0);

        // Round-robin over 4'b0101 with correct acks
        do_reset(4'b0101);
        for (int i = 0; i < 4; i++) begin
            do_pkt(0, 3, 2, 4'b0101);
            if (i == 0) chk("mem_latency", last_s - rel, 2);
            chk("rr_sel_lit", obs_sel, t2_sel[i]);
            chk("rr_sn_lit", obs_sn, t2_sn[i]);
        end

        // No ack: dup 1..3, then resync
        do_reset(4'b0100);
        r0 = rsn_cnt;
        for (int i = 0; i < 3; i++) begin
            do_pkt(2, 1, 2, 4'b0100);
            chk("retx_sn_lit", obs_sn, t3_sn[i]);
        end
        do_pkt(0, 2, 2, 4'b0100);
        chk("resync_pulses", rsn_cnt - r0, 1);
        chk("post_resync_sn_lit", obs_sn, 4'h5);

        // Wrong ack ignored; ack on the timeout clock wins
        do_reset(4'b0001);
        do_pkt(1, 5, 2, 4'b0001);
        chk("wrong_ack_sn_lit", obs_sn, 4'h5);
        do_pkt(0, TMO, 2, 4'b0001);
        chk("retx_after_wrong_lit", obs_sn, 4'h9);
        do_pkt(0, 2, 2, 4'b0001);
        chk("ack_at_tmo_adv_lit", obs_sn, 4'h6);

        // Asynchronous reset while EthSend is busy
        do_reset(4'b0010);
        do_pkt(0, 2, 2, 4'b0010);
        wait_start();
        chk("pre_rst_sn_lit", obs_sn, 4'h6);
        busy_i = 1; in_flight = 1;
        repeat (2) @(posedge clk);
        #2 chk_en = 0; in_flight = 0; reset_i = 1;
        #1;
        chk("async_src_en", src_en_o, 0); chk("async_start", start_o, 0);
        chk("async_sel", sel_o, 0);       chk("async_sched_busy", sched_busy_o, 0);
        do_reset(4'b0010);
        do_pkt(0, 2, 2, 4'b0010);
        chk("post_rst_sn_lit", obs_sn, 4'h5);

        // Random traffic
        do_reset(NSRC'($urandom_range(1, 2**NSRC - 1)));
        for (int i = 0; i < 300; i++) begin
            r0 = $urandom_range(0, 99);
            resp = (r0 < 70) ? 0 : (r0 < 80) ? 1 : (r0 < 95) ? 2 : 3;
            do_pkt(resp, (resp == 1) ? $urandom_range(1, TMO - 1) : $urandom_range(1, TMO),
                   $urandom_range(1, 6), NSRC'($urandom_range(1, 2**NSRC - 1)));
        end
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule

// File: doc/eth_send_sched.md
Name: eth_send_sched

Overview:
- Scheduler/sequencer in front of EthSend; decides what each Ethernet packet carries and drives EthSend's start/sel/sn/reset_sn controls.
- Scans NSRC ModifChk/Arbiter2 pairs for dirty regions and shares the single EthSend between them round-robin.
- Sends background (BG) keep-alive packets when idle, tracks 2-bit sequence numbers, and retransmits unacknowledged MEM packets with increasing dup count.

Parameters:
NSRC, 4, number of memory sources (1..64); source i is sent as sel = {2'b10, i[5:0]}
BG_PERIOD, 1000, idle clocks between BG keep-alive packets
ACK_TMO, 4000, clocks after done with no matching ack before retransmit
MAX_DUP, 3, highest dup value; exceeding it forces SN resync

Ports:
clk  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
dirty_i  in  NSRC  per-source "ModifChk has pending region" flag
src_en_o  out  NSRC  one-hot enable of the selected ModifChk+Arbiter2 (drives their bus signals)
start_o  out  1  one-clock start pulse to EthSend.start_i
reset_sn_o  out  1  one-clock pulse to EthSend.reset_sn_i
sel_o  out  8  to EthSend.sel_i; 8'h00 = BG, {2'b10,idx} = MEM
sn_o  out  4  to EthSend.sn_i; [3:2] = dup, [1:0] = sn
busy_i  in  1  EthSend.busy_o
done_i  in  1  EthSend.done_o (one-clock pulse)
ack_valid_i  in  1  receive path saw an ack
ack_sn_i  in  2  sn carried by that ack
sched_busy_o  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset values: src_en_o = 0, start_o = 0, reset_sn_o = 0, sel_o = 0, sn_o = 0, sched_busy_o = 0. Internal state: cur_sn = 1, rr_ptr = 0, bg_cnt = 0. State = IDLE.
- Reset is asynchronous and may assert mid-packet. All outputs return to reset values immediately. No completion is awaited.
- SN rule:
  - MEM packets use cur_sn in 1..3. After an acked packet, cur_sn advances 1->2->3->1 (0 is never used for MEM).
  - BG packets use sn = 0, dup = 0.
- States:
  - IDLE:
    - If any dirty_i, pick the first set bit at or after rr_ptr (wrapping) -> ARM with dup = 1.
    - Else bg_cnt increments; when it reaches BG_PERIOD-1 -> ARM_BG, and bg_cnt clears.
    - Dirty takes priority over a simultaneous BG expiry.
  - ARM / ARM_BG:
    - Drive src_en_o (one-hot, MEM only), sel_o and sn_o for one settle clock.
    - Next clock: start_o = 1 for exactly one clock -> WAIT_DONE.
  - WAIT_DONE:
    - Hold src_en_o, sel_o and sn_o stable until done_i.
    - On done_i: src_en_o -> 0. BG goes -> IDLE; MEM goes -> WAIT_ACK with tmo counter = 0.
    - busy_i is informational only; if busy_i does not rise within 4 clocks of start_o, treat as done (fault) and go to IDLE.
  - WAIT_ACK:
    - ack_valid_i with ack_sn_i == cur_sn: advance cur_sn, set rr_ptr = idx+1 mod NSRC -> IDLE.
    - A non-matching ack is ignored.
    - tmo reaching ACK_TMO-1: if dup < MAX_DUP, dup++ -> ARM (same source, same cur_sn); else -> RESYNC.
    - An ack arriving in the same clock as timeout expiry wins.
  - RESYNC: reset_sn_o = 1 for one clock; cur_sn = 1; rr_ptr = idx+1 -> IDLE. The source stays dirty and is rescheduled later.
- src_en_o is never asserted in BG, IDLE, WAIT_ACK or RESYNC.
- start_o is never asserted while busy_i = 1.
- Latency: dirty_i rising in IDLE -> start_o 2 clocks later.
- dirty_i dropping while a packet is in flight has no effect on the current packet.

Test Plan:
1. Reset, dirty_i = 0, BG_PERIOD = 10 -> start_o every ~10+done clocks, with sel_o = 8'h00, sn_o = 4'h0 and src_en_o = 0 throughout.
2. dirty_i = 4'b0101, ack each packet with the correct sn:
   - sends go src0 (sel 8'h80, sn_o 4'h5), src2 (8'h82, 4'h6), src0 (8'h80, 4'h7), src2 (8'h82, 4'h5).
   - src_en_o is one-hot and matches sel_o.
3. Single dirty source, no ack:
   - retransmits with sn_o 4'h5, 4'h9, 4'hD.
   - then reset_sn_o pulses once, and the next packet is sn_o 4'h5.
4. Ack with wrong sn (2 while cur_sn = 1) -> ignored, retransmit occurs. Ack on the same clock as timeout -> no retransmit, cur_sn advances.
5. Assert reset_i during WAIT_DONE -> start_o/src_en_o drop asynchronously and cur_sn = 1; after release, the first MEM packet uses sn_o 4'h5.
6. Close the loop: connect EthSend + BEthRx model, run random dirty/ack traffic for 10k packets -> zero receiver errors and no start_o while busy_i.
